// File: rtl/branch_resolve_unit.sv
// Branch/jump/trap resolution in EX with a 2-bit-counter BHT for IF-stage prediction.
// Emits a registered one-shot redirect/flush and runs the ECALL/EBREAK trap handshake.
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic             cf,
  input  logic             zf,
  input  logic             vf,
  input  logic             sf,
  input  logic             ef,
  input  logic [XLEN-1:0]  ex_br_target,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  trap_vector,
  output logic             trap_req,
  input  logic             trap_ack,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       pc_sel,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_TRAP = 1'b1;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_JALR = 2'b01;
  localparam logic [1:0] SEL_TGT  = 2'b10;
  localparam logic [1:0] SEL_TRAP = 2'b11;

  logic [0:0]       state;
  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             fire;
  logic             is_cond;
  logic             actual_taken;
  logic             mispred;
  logic             trap_entry;
  logic             nxt_rv;
  logic [1:0]       nxt_sel;
  logic [XLEN-1:0]  nxt_pc;

  assign if_idx        = if_pc[IDX_LSB +: IDX_W];
  assign ex_idx        = ex_pc[IDX_LSB +: IDX_W];
  assign if_pred_taken = bht[if_idx][1];
  assign ex_ready      = (state == S_IDLE);
  assign trap_req      = (state == S_TRAP);
  assign fire          = ex_valid && ex_ready;
  assign trap_entry    = fire && (ex_opcode == OP_SYSTEM) && ef;
  assign mispred       = is_cond && (actual_taken != ex_pred_taken);

  always_comb begin
    is_cond      = 1'b0;
    actual_taken = 1'b0;
    if (fire && ex_opcode == OP_BRANCH) begin
      is_cond = 1'b1;
      unique case (ex_funct3)
        3'b000:  actual_taken = zf;
        3'b001:  actual_taken = !zf;
        3'b100:  actual_taken = (sf != vf);
        3'b101:  actual_taken = (sf == vf);
        3'b110:  actual_taken = !cf;
        3'b111:  actual_taken = cf;
        default: is_cond      = 1'b0;
      endcase
    end
  end

  // Trap return shares the redirect path; EX is stalled while trapped so they never collide.
  always_comb begin
    nxt_rv  = 1'b0;
    nxt_sel = SEL_SEQ;
    nxt_pc  = redirect_pc;
    if (state == S_TRAP) begin
      if (trap_ack) begin
        nxt_rv  = 1'b1;
        nxt_sel = SEL_TRAP;
        nxt_pc  = trap_vector;
      end
    end else if (fire) begin
      if (mispred) begin
        nxt_rv  = 1'b1;
        nxt_sel = actual_taken ? SEL_TGT : SEL_SEQ;
        nxt_pc  = actual_taken ? ex_br_target : ex_pc + XLEN'(4);
      end else if (ex_opcode == OP_JAL) begin
        nxt_rv  = 1'b1;
        nxt_sel = SEL_TGT;
        nxt_pc  = ex_br_target;
      end else if (ex_opcode == OP_JALR) begin
        nxt_rv  = 1'b1;
        nxt_sel = SEL_JALR;
        nxt_pc  = {ex_alu_result[XLEN-1:1], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      pc_sel         <= SEL_SEQ;
      flush          <= 1'b0;
    end else begin
      redirect_valid <= nxt_rv;
      redirect_pc    <= nxt_pc;
      pc_sel         <= nxt_sel;
      flush          <= nxt_rv || trap_entry;
      if (state == S_TRAP) begin
        if (trap_ack) state <= S_IDLE;
      end else if (trap_entry) begin
        state <= S_TRAP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (is_cond) begin
      if (actual_taken && bht[ex_idx] != 2'b11)
        bht[ex_idx] <= bht[ex_idx] + 2'd1;
      else if (!actual_taken && bht[ex_idx] != 2'b00)
        bht[ex_idx] <= bht[ex_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (is_cond && br_count != '1)     br_count      <= br_count + CNT_W'(1);
      if (mispred && mispred_count != '1) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed bench for branch_resolve_unit against a behavioural model
// (per-index counters as plain ints, saturating statistics, trap mode flag).
module tb_branch_resolve_unit;
  localparam int XLEN = 32;
  localparam int NENT = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_ready;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            cf, zf, vf, sf, ef;
  logic [XLEN-1:0] ex_br_target;
  logic [XLEN-1:0] ex_alu_result;
  logic [XLEN-1:0] trap_vector;
  logic            trap_req;
  logic            trap_ack;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      pc_sel;
  logic            flush;
  logic [CW-1:0]   br_count;
  logic [CW-1:0]   mispred_count;

  branch_resolve_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(NENT), .IDX_LSB(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .cf(cf), .zf(zf), .vf(vf), .sf(sf), .ef(ef),
    .ex_br_target(ex_br_target), .ex_alu_result(ex_alu_result), .trap_vector(trap_vector),
    .trap_req(trap_req), .trap_ack(trap_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc_sel(pc_sel),
    .flush(flush), .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  int m_bht [NENT];
  int m_br;
  int m_mis;
  bit m_trap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_bht[i] = 1;
    m_br = 0;
    m_mis = 0;
    m_trap = 0;
  endtask

  task automatic set_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [XLEN-1:0] pc, input logic pred, input logic [XLEN-1:0] tgt);
    ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_pc = pc;
    ex_pred_taken = pred; ex_br_target = tgt;
  endtask

  // Called just after a rising edge with inputs driven; returns just after the next edge.
  task automatic cycle();
    bit e_rv, e_fl, taken, cond;
    logic [1:0] e_sel;
    logic [XLEN-1:0] e_pc;
    #3;
    check("if_pred_taken", if_pred_taken, m_bht[idx_of(if_pc)] >= 2);
    check("ex_ready", ex_ready, !m_trap);
    e_rv = 0; e_fl = 0; e_sel = 2'b00; e_pc = '0; taken = 0; cond = 0;
    if (m_trap) begin
      if (trap_ack) begin
        e_rv = 1; e_fl = 1; e_sel = 2'b11; e_pc = trap_vector; m_trap = 0;
      end
    end else if (ex_valid) begin
      case (ex_opcode)
        OP_BRANCH: begin
          cond = 1;
          case (ex_funct3)
            3'd0: taken = zf;
            3'd1: taken = !zf;
            3'd4: taken = (sf != vf);
            3'd5: taken = (sf == vf);
            3'd6: taken = !cf;
            3'd7: taken = cf;
            default: cond = 0;
          endcase
          if (cond) begin
            int i;
            i = idx_of(ex_pc);
            m_bht[i] = taken ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3)
                             : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
            if (m_br < CMAX) m_br++;
            if (taken != ex_pred_taken) begin
              if (m_mis < CMAX) m_mis++;
              e_rv = 1; e_fl = 1;
              e_sel = taken ? 2'b10 : 2'b00;
              e_pc  = taken ? ex_br_target : ex_pc + 32'd4;
            end
          end
        end
        OP_JAL:  begin e_rv = 1; e_fl = 1; e_sel = 2'b10; e_pc = ex_br_target; end
        OP_JALR: begin e_rv = 1; e_fl = 1; e_sel = 2'b01; e_pc = ex_alu_result & ~32'd1; end
        OP_SYSTEM: if (ef) begin e_fl = 1; m_trap = 1; end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check("redirect_valid", redirect_valid, e_rv);
    check("flush", flush, e_fl);
    check("trap_req", trap_req, m_trap);
    check("br_count", br_count, m_br);
    check("mispred_count", mispred_count, m_mis);
    if (e_rv) begin
      check("redirect_pc", redirect_pc, e_pc);
      check("pc_sel", pc_sel, e_sel);
    end
  endtask

  task automatic idle_inputs();
    set_ex(1'b0, OP_ALU, 3'd0, '0, 1'b0, '0);
    {cf, zf, vf, sf, ef} = '0;
    trap_ack = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [5];
    ops[0] = OP_BRANCH; ops[1] = OP_JAL; ops[2] = OP_JALR; ops[3] = OP_SYSTEM; ops[4] = OP_ALU;
    rst_n = 1'b0;
    idle_inputs();
    if_pc = '0;
    ex_alu_result = '0;
    trap_vector = 32'h0000_8000;
    model_reset();
    #2;
    check("rst_redirect_valid", redirect_valid, 1'b0);
    check("rst_pc_sel", pc_sel, 2'b00);
    check("rst_redirect_pc", redirect_pc, '0);
    check("rst_trap_req", trap_req, 1'b0);
    check("rst_counts", {br_count, mispred_count}, '0);
    for (int i = 0; i < NENT; i++) begin
      if_pc = XLEN'(i * 4);
      #1 check("rst_pred", if_pred_taken, 1'b0);
    end
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // BEQ taken, predicted not-taken
    set_ex(1'b1, OP_BRANCH, 3'd0, 32'h100, 1'b0, 32'h140); zf = 1'b1; if_pc = 32'h100;
    cycle();
    idle_inputs(); if_pc = 32'h100;
    cycle();

    // BNE not taken, predicted taken; then four more not-taken
    set_ex(1'b1, OP_BRANCH, 3'd1, 32'h200, 1'b1, 32'h280); zf = 1'b1; if_pc = 32'h200;
    cycle();
    for (int k = 0; k < 4; k++) begin
      set_ex(1'b1, OP_BRANCH, 3'd1, 32'h200, 1'b0, 32'h280); zf = 1'b1;
      cycle();
    end
    idle_inputs();
    cycle();

    // JALR clears LSB, single pulse
    set_ex(1'b1, OP_JALR, 3'd0, 32'h300, 1'b0, '0); ex_alu_result = 32'h3001;
    cycle();
    idle_inputs();
    cycle();
    cycle();

    // ECALL, stalled mispredicting BEQs, then ack
    set_ex(1'b1, OP_SYSTEM, 3'd0, 32'h400, 1'b0, '0); ef = 1'b1;
    cycle();
    ef = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_ex(1'b1, OP_BRANCH, 3'd0, 32'h100, 1'b0, 32'h500); zf = 1'b1;
      cycle();
    end
    trap_ack = 1'b1; ex_valid = 1'b0;
    cycle();
    idle_inputs(); trap_ack = 1'b1;
    cycle();
    trap_ack = 1'b0;

    // SYSTEM without ef does nothing
    set_ex(1'b1, OP_SYSTEM, 3'd0, 32'h404, 1'b0, '0);
    cycle();

    // Saturate mispred_count with alternating mispredicts
    for (int k = 0; k < 20; k++) begin
      set_ex(1'b1, OP_BRANCH, 3'd6, 32'h600, k[0], 32'h700); cf = k[0];
      cycle();
    end

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 4)];
      set_ex($urandom_range(0, 3) != 0, op, 3'($urandom), 32'($urandom_range(0, 255)) << 2,
             1'($urandom), $urandom);
      {cf, zf, vf, sf} = 4'($urandom);
      ef = (op == OP_SYSTEM) ? ($urandom_range(0, 2) == 0) : 1'($urandom);
      ex_alu_result = $urandom;
      trap_vector = $urandom;
      trap_ack = ($urandom_range(0, 2) == 0);
      if_pc = ($urandom_range(0, 3) == 0) ? ex_pc : 32'($urandom_range(0, 255)) << 2;
      cycle();
    end

    // Asynchronous reset while trapped
    idle_inputs();
    while (m_trap) begin trap_ack = 1'b1; cycle(); end
    idle_inputs();
    set_ex(1'b1, OP_SYSTEM, 3'd0, 32'h900, 1'b0, '0); ef = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_trap_req", trap_req, 1'b0);
    check("async_ex_ready", ex_ready, 1'b1);
    check("async_flush", flush, 1'b0);
    check("async_counts", {br_count, mispred_count}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
